mem_sys: RTL and testbench

Memory subsystem that sits directly downstream of the CPU core and serves all of its memory requests. It holds a word-addressed RAM for instructions and data plus a small memory-mapped I/O page: an LED register, a free-running cycle counter, and a UART transmitter behind a FIFO. The core runs without stalls, so the block answers every read in the same cycle and commits every write on the next rising clock edge.

---
 rtl/mem_sys.sv | 215 +++++++++++++++++++++
 tb/tb_mem_sys.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sys.sv
// Memory subsystem for a stall-free core: word RAM plus an I/O page with LEDs,
// a free-running cycle counter and a FIFO-fed 8N1 UART transmitter.
module mem_sys #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned RAM_WORDS    = 256,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memread_i,
   input  logic             memwrite_i,
   input  logic [WIDTH-1:0] memaddr_i,
   input  logic [WIDTH-1:0] memwdata_i,
   output logic [WIDTH-1:0] memrdata_o,
   output logic             uart_tx_o,
   output logic [15:0]      led_o
);

   localparam int unsigned RamAw = $clog2(RAM_WORDS);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [WIDTH-1:0] AddrLed    = WIDTH'(32'hFFFF_0000);
   localparam logic [WIDTH-1:0] AddrData   = WIDTH'(32'hFFFF_0004);
   localparam logic [WIDTH-1:0] AddrStatus = WIDTH'(32'hFFFF_0008);
   localparam logic [WIDTH-1:0] AddrCycle  = WIDTH'(32'hFFFF_000C);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

   // Address decode on the word address; byte offset bits are ignored
   logic             sel_ram, sel_led, sel_data, sel_status, sel_cycle;
   logic [RamAw-1:0] ram_idx;

   assign sel_ram    = (memaddr_i[WIDTH-1:RamAw+2] == '0);
   assign sel_led    = (memaddr_i[WIDTH-1:2] == AddrLed[WIDTH-1:2]);
   assign sel_data   = (memaddr_i[WIDTH-1:2] == AddrData[WIDTH-1:2]);
   assign sel_status = (memaddr_i[WIDTH-1:2] == AddrStatus[WIDTH-1:2]);
   assign sel_cycle  = (memaddr_i[WIDTH-1:2] == AddrCycle[WIDTH-1:2]);
   assign ram_idx    = memaddr_i[RamAw+1:2];

   logic unused_ok;
   assign unused_ok = ^{memread_i, memaddr_i[1:0]};

   logic [WIDTH-1:0] ram_q [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (memwrite_i && sel_ram) begin
         ram_q[ram_idx] <= memwdata_i;
      end
   end

   logic [15:0]      led_q, led_d;
   logic [WIDTH-1:0] cycle_q, cycle_d;

   // FIFO state
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            fifo_full, fifo_empty, push_req, push, pop;

   // UART state
   tx_state_e       state_q, state_d;
   logic [CntW-1:0] baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            baud_last, tx_busy;

   assign fifo_full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign pop        = (state_q == StIdle) && !fifo_empty;
   assign push_req   = memwrite_i && sel_data;
   // A full FIFO still accepts a push when a pop frees a slot on the same edge
   assign push       = push_req && (!fifo_full || pop);
   assign baud_last  = (baud_q == CntW'(CLKS_PER_BIT - 1));
   assign tx_busy    = (state_q != StIdle);

   always_comb begin
      led_d      = led_q;
      cycle_d    = cycle_q + 1'b1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (memwrite_i && sel_led) begin
         led_d = memwdata_i[15:0];
      end
      if (memwrite_i && sel_cycle) begin
         cycle_d = '0;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      if (push_req && !push) begin
         overflow_d = 1'b1;
      end else if (memwrite_i && sel_status && memwdata_i[3]) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d = StStart;
               shift_d = fifo_q[rd_ptr_q];
               baud_d  = '0;
            end
         end
         StStart: begin
            if (baud_last) begin
               state_d = StData;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_last) begin
               state_d = StIdle;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= memwdata_i[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q      <= '0;
         cycle_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= StIdle;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
      end else begin
         led_q      <= led_d;
         cycle_q    <= cycle_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
      end
   end

   always_comb begin
      case (state_q)
         StStart: uart_tx_o = 1'b0;
         StData:  uart_tx_o = shift_q[0];
         default: uart_tx_o = 1'b1;
      endcase
   end

   always_comb begin
      memrdata_o = '0;
      if (sel_ram) begin
         memrdata_o = ram_q[ram_idx];
      end else if (sel_led) begin
         memrdata_o = {{(WIDTH-16){1'b0}}, led_q};
      end else if (sel_status) begin
         memrdata_o = WIDTH'({overflow_q, tx_busy, fifo_empty, fifo_full});
      end else if (sel_cycle) begin
         memrdata_o = cycle_q;
      end
   end

   assign led_o = led_q;

endmodule

// File: tb/tb_mem_sys.sv
// Directed and randomized checks of mem_sys against a simple behavioural model:
// RAM array, expected UART byte lists and a serial-line frame decoder.
module tb_mem_sys;

   localparam int unsigned Cpb   = 4;
   localparam int unsigned Depth = 8;
   localparam logic [31:0] ALed  = 32'hFFFF_0000;
   localparam logic [31:0] AData = 32'hFFFF_0004;
   localparam logic [31:0] AStat = 32'hFFFF_0008;
   localparam logic [31:0] ACyc  = 32'hFFFF_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memread_i = 1'b0;
   logic        memwrite_i = 1'b0;
   logic [31:0] memaddr_i = '0;
   logic [31:0] memwdata_i = '0;
   logic [31:0] memrdata_o;
   logic        uart_tx_o;
   logic [15:0] led_o;

   mem_sys #(
      .WIDTH(32),
      .RAM_WORDS(256),
      .FIFO_DEPTH(Depth),
      .CLKS_PER_BIT(Cpb)
   ) dut (
      .clk(clk),
      .rst(rst),
      .memread_i(memread_i),
      .memwrite_i(memwrite_i),
      .memaddr_i(memaddr_i),
      .memwdata_i(memwdata_i),
      .memrdata_o(memrdata_o),
      .uart_tx_o(uart_tx_o),
      .led_o(led_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [31:0] ram_m [256];
   bit          ram_v [256];
   byte unsigned rx_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      memaddr_i  = a;
      memwdata_i = d;
      memwrite_i = 1'b1;
      tick();
      memwrite_i = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      memaddr_i = a;
      memread_i = 1'b1;
      #1;
      d = memrdata_o;
      memread_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
   endtask

   // Serial-line decoder: samples mid-bit, one byte per complete 10-bit frame
   initial begin
      int t;
      bit act;
      logic [7:0] b;
      act = 1'b0;
      t = 0;
      b = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 1'b0;
         end else if (!act) begin
            if (uart_tx_o == 1'b0) begin
               act = 1'b1;
               t = 1;
               b = '0;
            end
         end else begin
            if ((t % Cpb) == Cpb / 2 && t / Cpb >= 1 && t / Cpb <= 8) b[t / Cpb - 1] = uart_tx_o;
            if (t == 10 * Cpb - 1) begin
               rx_q.push_back(b);
               act = 1'b0;
            end
            t++;
         end
      end
   end

   initial begin
      logic [31:0] r, c1, c2, d, got;
      logic [9:0]  frame;
      byte unsigned sent[10];
      byte unsigned burst[3];
      int waited;
      bit all_high;

      for (int i = 0; i < 256; i++) ram_v[i] = 1'b0;

      // Reset state
      do_reset();
      chk("rst_led", {16'h0, led_o}, 32'h0);
      chk("rst_tx", {31'h0, uart_tx_o}, 32'h1);
      rd(AStat, r); chk("rst_status", r, 32'h2);
      rd(ACyc, r);  chk("rst_cycle", r, 32'h0);

      // RAM directed
      wr(32'h40, 32'hDEAD_BEEF);
      ram_m[16] = 32'hDEAD_BEEF; ram_v[16] = 1'b1;
      rd(32'h40, r);  chk("ram_40", r, 32'hDEAD_BEEF);
      rd(32'h43, r);  chk("ram_43", r, 32'hDEAD_BEEF);
      rd(32'h400, r); chk("unmapped_400", r, 32'h0);
      wr(32'h440, 32'h1111_2222);
      rd(32'h40, r);  chk("no_alias", r, 32'hDEAD_BEEF);
      rd(32'h440, r); chk("unmapped_440", r, 32'h0);

      // Random RAM traffic; writes also hold read high to observe pre-write data
      for (int i = 0; i < 60; i++) begin
         int w;
         w = $urandom_range(0, 255);
         memaddr_i = {22'h0, w[7:0], 2'($urandom_range(0, 3))};
         memread_i = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            memwdata_i = d;
            memwrite_i = 1'b1;
            #1;
            if (ram_v[w]) chk("ram_prewrite", memrdata_o, ram_m[w]);
            tick();
            memwrite_i = 1'b0;
            ram_m[w] = d; ram_v[w] = 1'b1;
            #1;
            chk("ram_postwrite", memrdata_o, d);
         end else begin
            #1;
            if (ram_v[w]) chk("ram_read", memrdata_o, ram_m[w]);
         end
         memread_i = 1'b0;
         rd(32'h400 + 32'($urandom_range(0, 4000)) * 4, r);
         chk("unmapped_rand", r, 32'h0);
         tick();
      end

      // LED
      wr(ALed, 32'h1234_ABCD);
      chk("led_out", {16'h0, led_o}, 32'h0000_ABCD);
      rd(ALed, r); chk("led_read", r, 32'h0000_ABCD);
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         wr(ALed, d);
         chk("led_rand", {16'h0, led_o}, {16'h0, d[15:0]});
      end
      do_reset();
      chk("led_reset", {16'h0, led_o}, 32'h0);
      rd(32'h40, r); chk("ram_keeps_reset", r, 32'hDEAD_BEEF);

      // Cycle counter
      rd(ACyc, c1);
      ticks(5);
      rd(ACyc, c2);
      chk("cycle_diff", c2 - c1, 32'd5);
      wr(ACyc, $urandom);
      rd(ACyc, r); chk("cycle_clr0", r, 32'd0);
      tick();
      rd(ACyc, r); chk("cycle_clr1", r, 32'd1);

      // Single UART frame, bit by bit
      rx_q.delete();
      wr(AData, 32'hABCD_EF55);
      chk("frame_pre_tx", {31'h0, uart_tx_o}, 32'h1);
      rd(AStat, r); chk("frame_pre_status", r, 32'h0);
      tick();
      frame = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10 * Cpb; i++) begin
         chk("frame_bit", {31'h0, uart_tx_o}, {31'h0, frame[i / Cpb]});
         rd(AStat, r); chk("frame_busy", {31'h0, r[2]}, 32'h1);
         tick();
      end
      chk("frame_post_tx", {31'h0, uart_tx_o}, 32'h1);
      rd(AStat, r); chk("frame_post_status", r, 32'h2);
      chk("frame_rx_count", rx_q.size(), 32'd1);
      got = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hxxxx_xxxx;
      chk("frame_rx_byte", got, 32'h55);

      // FIFO full and overflow: one byte leaves for the shifter, Depth more fit
      rx_q.delete();
      for (int k = 0; k < 10; k++) begin
         sent[k] = 8'($urandom);
         wr(AData, {24'($urandom), sent[k]});
         if (k == Depth) begin
            rd(AStat, r); chk("fifo_full", r, 32'h5);
         end
      end
      rd(AStat, r); chk("fifo_overflow", r, 32'hD);
      wr(AStat, 32'hFFFF_FFF7);
      rd(AStat, r); chk("ovf_keep", r, 32'hD);
      wr(AStat, 32'h8);
      rd(AStat, r); chk("ovf_clear", r, 32'h5);
      waited = 0;
      while (rx_q.size() < Depth + 1 && waited < 2000) begin
         tick();
         waited++;
      end
      ticks(100);
      chk("fifo_frames", rx_q.size(), Depth + 1);
      for (int k = 0; k < Depth + 1; k++) begin
         got = (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hxxxx_xxxx;
         chk("fifo_byte", got, 32'(sent[k]));
      end
      rd(AStat, r); chk("fifo_drained", r, 32'h2);

      // Random bytes with random spacing
      rx_q.delete();
      for (int k = 0; k < 3; k++) begin
         burst[k] = 8'($urandom);
         wr(AData, 32'(burst[k]));
         ticks($urandom_range(0, 50));
      end
      waited = 0;
      while (rx_q.size() < 3 && waited < 1000) begin
         tick();
         waited++;
      end
      ticks(20);
      chk("burst_frames", rx_q.size(), 32'd3);
      for (int k = 0; k < 3; k++) begin
         got = (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hxxxx_xxxx;
         chk("burst_byte", got, 32'(burst[k]));
      end

      // Reset during the data phase with three bytes queued
      rx_q.delete();
      for (int k = 0; k < 4; k++) wr(AData, $urandom);
      ticks(3 * Cpb);
      rd(AStat, r); chk("pre_reset_busy", r, 32'h4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset_tx", {31'h0, uart_tx_o}, 32'h1);
      rd(AStat, r); chk("reset_status", r, 32'h2);
      all_high = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (uart_tx_o !== 1'b1) all_high = 1'b0;
         tick();
      end
      chk("reset_line_idle", {31'h0, all_high}, 32'h1);
      chk("reset_no_frames", rx_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
